// File: rtl/change_dispenser_if.sv
// Coin hopper handshake between the dispenser (master) and the hopper (slave).
// hop_valid/hop_den are held stable until hop_ack; a coin moves on any edge where both are high.
interface change_dispenser_if;
    logic       hop_valid;
    logic [1:0] hop_den;
    logic       hop_ack;

    modport master (output hop_valid, output hop_den, input hop_ack);
    modport slave  (input hop_valid, input hop_den, output hop_ack);
endinterface

// File: rtl/change_dispenser.sv
// Greedy coin payout engine with per-denomination inventory, refill and shortfall reporting.
// Handshakes: start is taken on an edge with ready=1; a coin is ejected on an edge with hop_valid=1 and hop_ack=1.
module change_dispenser #(
    parameter int CNT_W   = 6,
    parameter int INIT_1  = 10,
    parameter int INIT_5  = 10,
    parameter int INIT_10 = 10,
    parameter int INIT_50 = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            amount,
    output logic                  ready,
    output logic                  done,
    output logic [7:0]            shortfall,
    input  logic                  refill,
    input  logic [1:0]            refill_den,
    input  logic [CNT_W-1:0]      refill_cnt,
    output logic [3:0]            inv_empty,
    output logic [1:0]            state_dbg,
    output logic [3:0][CNT_W-1:0] inv_dbg,
    change_dispenser_if.master    hop
);

    typedef enum logic [1:0] {IDLE, SELECT, ISSUE, DONE} state_t;

    state_t                  state;
    logic [7:0]              remaining;
    logic [3:0][CNT_W-1:0]   inv;
    logic [3:0][CNT_W-1:0]   inv_next;
    logic [3:0][CNT_W:0]     inv_sum;
    logic                    sel_found;
    logic [1:0]              sel_den;
    logic                    coin_taken;

    function automatic logic [7:0] den_value(input logic [1:0] d);
        case (d)
            2'd0:    den_value = 8'd1;
            2'd1:    den_value = 8'd5;
            2'd2:    den_value = 8'd10;
            default: den_value = 8'd50;
        endcase
    endfunction

    // Ascending scan: the last qualifying denomination is the largest one.
    always_comb begin
        sel_found = 1'b0;
        sel_den   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (den_value(2'(k)) <= remaining && inv[k] != '0) begin
                sel_found = 1'b1;
                sel_den   = 2'(k);
            end
        end
    end

    assign coin_taken = (state == ISSUE) && hop.hop_ack;

    // One extra bit catches refill overflow; the decrement never underflows
    // because a coin is only requested from a non-empty bin.
    always_comb begin
        inv_sum  = '0;
        inv_next = inv;
        for (int k = 0; k < 4; k++) begin
            inv_sum[k] = {1'b0, inv[k]};
            if (refill && refill_den == 2'(k))
                inv_sum[k] = inv_sum[k] + {1'b0, refill_cnt};
            if (coin_taken && hop.hop_den == 2'(k))
                inv_sum[k] = inv_sum[k] - (CNT_W+1)'(1);
            inv_next[k] = inv_sum[k][CNT_W] ? {CNT_W{1'b1}} : inv_sum[k][CNT_W-1:0];
        end
    end

    always_comb begin
        inv_empty = '0;
        for (int k = 0; k < 4; k++) begin
            inv_empty[k] = (inv[k] == '0);
        end
    end

    assign state_dbg = state;
    assign inv_dbg   = inv;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            ready         <= 1'b1;
            hop.hop_valid <= 1'b0;
            hop.hop_den   <= 2'd0;
            done          <= 1'b0;
            shortfall     <= 8'd0;
            remaining     <= 8'd0;
            inv[0]        <= CNT_W'(INIT_1);
            inv[1]        <= CNT_W'(INIT_5);
            inv[2]        <= CNT_W'(INIT_10);
            inv[3]        <= CNT_W'(INIT_50);
        end else begin
            inv <= inv_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        remaining <= amount;
                        shortfall <= 8'd0;
                        ready     <= 1'b0;
                        state     <= SELECT;
                    end
                end
                SELECT: begin
                    if (sel_found) begin
                        hop.hop_den   <= sel_den;
                        hop.hop_valid <= 1'b1;
                        state         <= ISSUE;
                    end else begin
                        done      <= 1'b1;
                        shortfall <= remaining;
                        state     <= DONE;
                    end
                end
                ISSUE: begin
                    if (hop.hop_ack) begin
                        remaining     <= remaining - den_value(hop.hop_den);
                        hop.hop_valid <= 1'b0;
                        state         <= SELECT;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: two instances (default inventory and a sparse one),
// hopper models with programmable ack delay, and a scoreboard of expected coins and done events.
module tb_change_dispenser;
    localparam int CNT_W = 6;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic                  start_a, start_b;
    logic [7:0]            amount_a, amount_b;
    logic                  ready_a, ready_b, done_a, done_b;
    logic [7:0]            shortfall_a, shortfall_b;
    logic                  refill_a, refill_b;
    logic [1:0]            refill_den_a, refill_den_b;
    logic [CNT_W-1:0]      refill_cnt_a, refill_cnt_b;
    logic [3:0]            inv_empty_a, inv_empty_b;
    logic [1:0]            state_a, state_b;
    logic [3:0][CNT_W-1:0] inv_a, inv_b;

    change_dispenser_if hop_a ();
    change_dispenser_if hop_b ();

    change_dispenser #(.CNT_W(CNT_W)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .amount(amount_a),
        .ready(ready_a), .done(done_a), .shortfall(shortfall_a),
        .refill(refill_a), .refill_den(refill_den_a), .refill_cnt(refill_cnt_a),
        .inv_empty(inv_empty_a), .state_dbg(state_a), .inv_dbg(inv_a), .hop(hop_a.master)
    );

    change_dispenser #(.CNT_W(CNT_W), .INIT_1(1), .INIT_5(0), .INIT_10(0), .INIT_50(0)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .amount(amount_b),
        .ready(ready_b), .done(done_b), .shortfall(shortfall_b),
        .refill(refill_b), .refill_den(refill_den_b), .refill_cnt(refill_cnt_b),
        .inv_empty(inv_empty_b), .state_dbg(state_b), .inv_dbg(inv_b), .hop(hop_b.master)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [8:0] exp_a_q[$];
    logic [8:0] exp_b_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic sb_pop(input int which, input logic [8:0] act, input string name);
        logic [8:0] e;
        if ((which == 0 && exp_a_q.size() == 0) || (which == 1 && exp_b_q.size() == 0)) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: got unexpected event %h expected none", name, act);
        end else begin
            e = (which == 0) ? exp_a_q.pop_front() : exp_b_q.pop_front();
            check(name, 32'(act), 32'(e));
        end
    endtask

    task automatic expect_coin(input int which, input logic [1:0] den);
        if (which == 0) exp_a_q.push_back({1'b0, 6'd0, den});
        else            exp_b_q.push_back({1'b0, 6'd0, den});
    endtask

    task automatic expect_done(input int which, input logic [7:0] sf);
        if (which == 0) exp_a_q.push_back({1'b1, sf});
        else            exp_b_q.push_back({1'b1, sf});
    endtask

    task automatic do_start(input int which, input logic [7:0] amt);
        @(posedge clk); #1;
        if (which == 0) begin start_a = 1'b1; amount_a = amt; end
        else            begin start_b = 1'b1; amount_b = amt; end
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic do_refill(input int which, input logic [1:0] den, input logic [CNT_W-1:0] cnt);
        @(posedge clk); #1;
        if (which == 0) begin refill_a = 1'b1; refill_den_a = den; refill_cnt_a = cnt; end
        else            begin refill_b = 1'b1; refill_den_b = den; refill_cnt_b = cnt; end
        @(posedge clk); #1;
        refill_a = 1'b0;
        refill_b = 1'b0;
    endtask

    task automatic wait_done(input int which, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = (which == 0) ? done_a : done_b;
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout_%0d: got no done within %0d cycles", which, budget);
        end
        @(negedge clk);
    endtask

    // Hopper models: ack after delay_x cycles of hop_valid, changed just after the rising edge.
    int delay_a = 0;
    int wait_a  = 0;
    int wait_b  = 0;
    bit refill_on_ack = 1'b0;

    initial begin
        hop_a.hop_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!hop_a.hop_valid) begin
                hop_a.hop_ack = 1'b0;
                wait_a = 0;
            end else if (wait_a >= delay_a) begin
                hop_a.hop_ack = 1'b1;
            end else begin
                wait_a++;
            end
            if (refill_on_ack) begin
                refill_a     = hop_a.hop_ack;
                refill_den_a = 2'd2;
                refill_cnt_a = CNT_W'(3);
            end
        end
    end

    initial begin
        hop_b.hop_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!hop_b.hop_valid) begin
                hop_b.hop_ack = 1'b0;
                wait_b = 0;
            end else begin
                hop_b.hop_ack = 1'b1;
            end
        end
    end

    logic       prev_valid_a = 1'b0, prev_valid_b = 1'b0;
    logic [1:0] prev_den_a = 2'd0, prev_den_b = 2'd0;

    always @(negedge clk) begin
        if (hop_a.hop_valid && prev_valid_a)
            check("den_stable_a", 32'(hop_a.hop_den), 32'(prev_den_a));
        if (hop_a.hop_valid && hop_a.hop_ack)
            sb_pop(0, {1'b0, 6'd0, hop_a.hop_den}, "coin_a");
        if (done_a)
            sb_pop(0, {1'b1, shortfall_a}, "done_a");
        prev_valid_a = hop_a.hop_valid;
        prev_den_a   = hop_a.hop_den;
    end

    always @(negedge clk) begin
        if (hop_b.hop_valid && prev_valid_b)
            check("den_stable_b", 32'(hop_b.hop_den), 32'(prev_den_b));
        if (hop_b.hop_valid && hop_b.hop_ack) begin
            sb_pop(1, {1'b0, 6'd0, hop_b.hop_den}, "coin_b");
            check("b_inv10_empty", 32'(inv_empty_b[2]), 32'd1);
        end
        if (done_b)
            sb_pop(1, {1'b1, shortfall_b}, "done_b");
        prev_valid_b = hop_b.hop_valid;
        prev_den_b   = hop_b.hop_den;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000ns");
        $fatal(1, "watchdog");
    end

    initial begin
        start_a = 0; amount_a = 0; refill_a = 0; refill_den_a = 0; refill_cnt_a = 0;
        start_b = 0; amount_b = 0; refill_b = 0; refill_den_b = 0; refill_cnt_b = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_ready", 32'(ready_a), 32'd1);
        check("rst_valid", 32'(hop_a.hop_valid), 32'd0);
        check("rst_den", 32'(hop_a.hop_den), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_shortfall", 32'(shortfall_a), 32'd0);
        check("rst_state", 32'(state_a), 32'd0);
        check("rst_inv_empty", 32'(inv_empty_a), 32'd0);
        for (int k = 0; k < 4; k++) check("rst_inv", 32'(inv_a[k]), 32'd10);

        // amount=0: done in the cycle after edge T+1
        expect_done(0, 8'd0);
        do_start(0, 8'd0);
        @(negedge clk);
        check("zero_done_early", 32'(done_a), 32'd0);
        check("zero_state_select", 32'(state_a), 32'd1);
        @(negedge clk);
        check("zero_done", 32'(done_a), 32'd1);
        @(negedge clk);
        check("zero_done_pulse", 32'(done_a), 32'd0);
        check("zero_ready", 32'(ready_a), 32'd1);

        // amount=67, zero-wait ack: 50,10,5,1,1
        expect_coin(0, 2'd3); expect_coin(0, 2'd2); expect_coin(0, 2'd1);
        expect_coin(0, 2'd0); expect_coin(0, 2'd0); expect_done(0, 8'd0);
        do_start(0, 8'd67);
        @(negedge clk);
        check("p67_valid_after_T", 32'(hop_a.hop_valid), 32'd0);
        @(negedge clk);
        check("p67_valid_after_T1", 32'(hop_a.hop_valid), 32'd1);
        check("p67_first_den", 32'(hop_a.hop_den), 32'd3);
        wait_done(0, 100);
        check("p67_ready", 32'(ready_a), 32'd1);
        check("p67_inv1", 32'(inv_a[0]), 32'd8);
        check("p67_inv5", 32'(inv_a[1]), 32'd9);
        check("p67_inv10", 32'(inv_a[2]), 32'd9);
        check("p67_inv50", 32'(inv_a[3]), 32'd9);

        // Slow ack for a 50 with a start pulsed mid-payout
        delay_a = 5;
        expect_coin(0, 2'd3); expect_done(0, 8'd0);
        do_start(0, 8'd50);
        repeat (2) @(negedge clk);
        do_start(0, 8'd5);
        wait_done(0, 100);
        delay_a = 0;
        check("slow_inv50", 32'(inv_a[3]), 32'd8);
        check("slow_inv5", 32'(inv_a[1]), 32'd9);

        // Asynchronous reset while in ISSUE
        delay_a = 30;
        do_start(0, 8'd50);
        repeat (3) @(negedge clk);
        check("arst_in_issue", 32'(state_a), 32'd2);
        #3 reset = 1'b1;
        #1;
        check("arst_valid", 32'(hop_a.hop_valid), 32'd0);
        check("arst_ready", 32'(ready_a), 32'd1);
        for (int k = 0; k < 4; k++) check("arst_inv", 32'(inv_a[k]), 32'd10);
        @(posedge clk);
        @(posedge clk); #1 reset = 1'b0;
        delay_a = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("arst_no_done", 32'(done_a), 32'd0);
        end

        // Refill and ack decrement on the same 10 bin, same edge
        refill_on_ack = 1'b1;
        expect_coin(0, 2'd2); expect_done(0, 8'd0);
        do_start(0, 8'd10);
        wait_done(0, 100);
        refill_on_ack = 1'b0;
        check("refill_ack_inv10", 32'(inv_a[2]), 32'd12);

        // Saturating and plain refills
        do_refill(0, 2'd0, CNT_W'(63));
        @(negedge clk);
        check("refill_sat_inv1", 32'(inv_a[0]), 32'd63);
        do_refill(0, 2'd3, CNT_W'(5));
        @(negedge clk);
        check("refill_inv50", 32'(inv_a[3]), 32'd15);

        // Sparse instance: only one 1-dollar coin
        check("b_rst_empty", 32'(inv_empty_b), 32'b1110);
        expect_coin(1, 2'd0); expect_done(1, 8'd2);
        do_start(1, 8'd3);
        wait_done(1, 100);
        check("b_short_shortfall", 32'(shortfall_b), 32'd2);
        check("b_short_empty", 32'(inv_empty_b), 32'b1111);

        // Sparse instance, no 10s: 20 paid as four 5s
        do_refill(1, 2'd1, CNT_W'(10));
        @(negedge clk);
        check("b_refill_inv5", 32'(inv_b[1]), 32'd10);
        for (int i = 0; i < 4; i++) expect_coin(1, 2'd1);
        expect_done(1, 8'd0);
        do_start(1, 8'd20);
        wait_done(1, 100);
        check("b_p20_inv5", 32'(inv_b[1]), 32'd6);
        check("b_p20_empty", 32'(inv_empty_b), 32'b1101);

        check("exp_a_drained", 32'(exp_a_q.size()), 32'd0);
        check("exp_b_drained", 32'(exp_b_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
